// File: rtl/alu_muldiv_unit_pkg.sv
// Shared types for the ALU / multiply-divide unit: internal ALU control,
// M-extension op select, iterative-unit FSM states and ALUOp classes.
package alu_muldiv_unit_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9
    } alu_ctrl_e;

    // Encoded exactly as funct3 so decode is a straight cast.
    typedef enum logic [2:0] {
        M_MUL    = 3'd0,
        M_MULH   = 3'd1,
        M_MULHSU = 3'd2,
        M_MULHU  = 3'd3,
        M_DIV    = 3'd4,
        M_DIVU   = 3'd5,
        M_REM    = 3'd6,
        M_REMU   = 3'd7
    } mop_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } mdu_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_RSVD  = 2'b11;

endpackage

// File: rtl/alu_muldiv_core.sv
// Iterative multiply/divide: one bit per cycle on operand magnitudes,
// sign fix-up applied when the result is presented in DONE.
module alu_muldiv_core
    import alu_muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            start,
    input  mop_e            mop,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            idle,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e          state, state_nx;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc, acc_step, prod;
    logic [XLEN-1:0]     mb, mag_a, mag_b, quo, rem;
    mop_e                op_q;
    logic                neg_q;
    logic                take, signed_a, signed_b, sa, sb;
    logic                div_zero, div_ovf, special, neg_start;
    logic [XLEN:0]       mul_sum, rem_sh, rem_diff;

    assign take = start && (state == ST_IDLE) && !flush;
    assign idle = (state == ST_IDLE);
    assign busy = (state == ST_CALC);
    assign done = (state == ST_DONE);

    // Operand conditioning at accept: signs, magnitudes, divide corner cases.
    always_comb begin
        signed_a  = (mop == M_MULH) || (mop == M_MULHSU) || (mop == M_DIV) || (mop == M_REM);
        signed_b  = (mop == M_MULH) || (mop == M_DIV) || (mop == M_REM);
        sa        = signed_a && a[XLEN-1];
        sb        = signed_b && b[XLEN-1];
        mag_a     = sa ? -a : a;
        mag_b     = sb ? -b : b;
        div_zero  = mop[2] && (b == '0);
        div_ovf   = mop[2] && signed_b && (a == MOST_NEG) && (b == '1);
        special   = div_zero || div_ovf;
        // Remainder takes the dividend's sign; everything else the xor.
        neg_start = (mop[2] && mop[1]) ? sa : (sa ^ sb);
    end

    // One iteration: shift-add multiply or restoring divide step.
    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, mb} : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        rem_diff = rem_sh - {1'b0, mb};
        if (op_q[2])
            acc_step = rem_diff[XLEN] ? {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                                      : {rem_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        else
            acc_step = {mul_sum, acc[XLEN-1:1]};
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    // FSM next state; flush wins over everything.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: if (take) state_nx = special ? ST_DONE : ST_CALC;
            ST_CALC: if (cnt == '0) state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
        if (flush) state_nx = ST_IDLE;
    end

    // Datapath: latch at accept, iterate in CALC. Corner cases preload the
    // final {rem, quo} so DONE needs no special path.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            acc   <= '0;
            mb    <= '0;
            op_q  <= M_MUL;
            neg_q <= 1'b0;
        end else if (take) begin
            op_q <= mop;
            mb   <= mag_b;
            cnt  <= CW'(XLEN-1);
            if (special) begin
                acc   <= div_zero ? {a, {XLEN{1'b1}}} : {{XLEN{1'b0}}, MOST_NEG};
                neg_q <= 1'b0;
            end else begin
                acc   <= {{XLEN{1'b0}}, mag_a};
                neg_q <= neg_start;
            end
        end else if (state == ST_CALC) begin
            cnt <= cnt - 1'b1;
            acc <= acc_step;
        end
    end

    // Sign-corrected result selection.
    always_comb begin
        prod = neg_q ? -acc : acc;
        quo  = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        case (op_q)
            M_MUL:                      result = prod[XLEN-1:0];
            M_MULH, M_MULHSU, M_MULHU:  result = prod[2*XLEN-1:XLEN];
            M_DIV, M_DIVU:              result = quo;
            default:                    result = rem;
        endcase
    end

endmodule

// File: rtl/alu_muldiv_unit.sv
// RV32/64-style ALU with optional iterative M-extension unit. Base ops are
// single-cycle; M ops stall the pipeline until the core reaches DONE.
module alu_muldiv_unit
    import alu_muldiv_unit_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit MDU_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      ALUOp,
    input  logic [2:0]      funct3,
    input  logic            op5,
    input  logic            funct7_5,
    input  logic            funct7_0,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    input  logic            in_valid,
    input  logic            flush,
    output logic [XLEN-1:0] ALUResult,
    output logic            Zero,
    output logic            stall,
    output logic            out_valid
);

    localparam int SW = $clog2(XLEN);

    alu_ctrl_e       ctrl;
    logic            is_m, m_start, m_idle, m_busy, m_done;
    logic [XLEN-1:0] alu_res, m_res;
    logic [SW-1:0]   shamt;

    assign shamt   = SrcB[SW-1:0];
    assign m_start = in_valid && is_m && MDU_EN && !flush && m_idle;

    // Decode ALUOp class + funct fields into internal control.
    always_comb begin
        ctrl = ALU_ADD;
        is_m = 1'b0;
        case (ALUOp)
            ALUOP_SUB: ctrl = ALU_SUB;
            ALUOP_FUNCT: begin
                if (op5 && funct7_0) is_m = 1'b1;
                else begin
                    case (funct3)
                        3'b000:  ctrl = (op5 && funct7_5) ? ALU_SUB : ALU_ADD;
                        3'b001:  ctrl = ALU_SLL;
                        3'b010:  ctrl = ALU_SLT;
                        3'b011:  ctrl = ALU_SLTU;
                        3'b100:  ctrl = ALU_XOR;
                        3'b101:  ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
                        3'b110:  ctrl = ALU_OR;
                        default: ctrl = ALU_AND;
                    endcase
                end
            end
            default: ctrl = ALU_ADD;
        endcase
    end

    // Single-cycle ALU.
    always_comb begin
        case (ctrl)
            ALU_SUB:  alu_res = SrcA - SrcB;
            ALU_SLL:  alu_res = SrcA << shamt;
            ALU_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, SrcA < SrcB};
            ALU_XOR:  alu_res = SrcA ^ SrcB;
            ALU_SRL:  alu_res = SrcA >> shamt;
            ALU_SRA:  alu_res = XLEN'($signed(SrcA) >>> shamt);
            ALU_OR:   alu_res = SrcA | SrcB;
            ALU_AND:  alu_res = SrcA & SrcB;
            default:  alu_res = SrcA + SrcB;
        endcase
    end

    generate
        if (MDU_EN) begin : g_mdu
            alu_muldiv_core #(.XLEN(XLEN)) u_core (
                .clk    (clk),
                .rst    (rst),
                .flush  (flush),
                .start  (m_start),
                .mop    (mop_e'(funct3)),
                .a      (SrcA),
                .b      (SrcB),
                .idle   (m_idle),
                .busy   (m_busy),
                .done   (m_done),
                .result (m_res)
            );
        end else begin : g_no_mdu
            assign m_idle = 1'b1;
            assign m_busy = 1'b0;
            assign m_done = 1'b0;
            assign m_res  = '0;
        end
    endgenerate

    // Output steering: reset forces idle outputs, DONE presents the M result,
    // CALC and the accept cycle stall, otherwise the base ALU answers.
    always_comb begin
        ALUResult = '0;
        stall     = 1'b0;
        out_valid = 1'b0;
        if (rst) begin
            ALUResult = '0;
        end else if (m_done) begin
            ALUResult = m_res;
            out_valid = !flush;
        end else if (m_busy) begin
            stall = 1'b1;
        end else if (is_m && MDU_EN) begin
            stall = m_start;
        end else if (in_valid) begin
            ALUResult = is_m ? '0 : alu_res;
            out_valid = 1'b1;
        end
    end

    assign Zero = (ALUResult == '0);

endmodule

// File: tb/tb_alu_muldiv_unit.sv
// Randomized + directed bench for alu_muldiv_unit (XLEN=32) against an
// arithmetic reference model.
module tb_alu_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ALUOp;
    logic [2:0]  funct3;
    logic        op5, funct7_5, funct7_0;
    logic [31:0] SrcA, SrcB;
    logic        in_valid, flush;
    logic [31:0] ALUResult;
    logic        Zero, stall, out_valid;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv_unit #(.XLEN(32), .MDU_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .ALUOp(ALUOp), .funct3(funct3), .op5(op5),
        .funct7_5(funct7_5), .funct7_0(funct7_0), .SrcA(SrcA), .SrcB(SrcB),
        .in_valid(in_valid), .flush(flush), .ALUResult(ALUResult), .Zero(Zero),
        .stall(stall), .out_valid(out_valid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Expected result and latency (cycles after the issue cycle until out_valid).
    function automatic void ref_model(input logic [1:0] aop, input logic [2:0] f3,
                                      input logic o5, input logic f75, input logic f70,
                                      input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output int lat);
        int          ia, ib;
        longint      la, lb, lbu, ps;
        logic [63:0] p;
        ia  = a;  ib = b;
        la  = ia; lb = ib;
        lbu = {32'b0, b};
        lat = 0;
        r   = '0;
        if (aop == 2'b01) r = a - b;
        else if (aop != 2'b10) r = a + b;
        else if (o5 && f70) begin
            lat = 33;
            case (f3)
                3'd0: r = a * b;
                3'd1: begin ps = la * lb;  p = ps; r = p[63:32]; end
                3'd2: begin ps = la * lbu; p = ps; r = p[63:32]; end
                3'd3: begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
                3'd4: if (b == 0) begin r = '1; lat = 1; end
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = a; lat = 1; end
                      else r = ia / ib;
                3'd5: if (b == 0) begin r = '1; lat = 1; end else r = a / b;
                3'd6: if (b == 0) begin r = a; lat = 1; end
                      else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin r = 0; lat = 1; end
                      else r = ia % ib;
                default: if (b == 0) begin r = a; lat = 1; end else r = a % b;
            endcase
        end else begin
            case (f3)
                3'd0: r = (o5 && f75) ? a - b : a + b;
                3'd1: r = a << b[4:0];
                3'd2: r = (ia < ib) ? 1 : 0;
                3'd3: r = (a < b) ? 1 : 0;
                3'd4: r = a ^ b;
                3'd5: r = f75 ? 32'(ia >>> b[4:0]) : a >> b[4:0];
                3'd6: r = a | b;
                default: r = a & b;
            endcase
        end
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return $urandom_range(0, 20);
            default: return $urandom;
        endcase
    endfunction

    // Issue one op, follow it to out_valid, scrambling operands while stalled.
    task automatic run_op(input string tag, input logic [1:0] aop, input logic [2:0] f3,
                          input logic o5, input logic f75, input logic f70,
                          input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        int          elat, n, sbad;
        ref_model(aop, f3, o5, f75, f70, a, b, er, elat);
        @(negedge clk);
        ALUOp = aop; funct3 = f3; op5 = o5; funct7_5 = f75; funct7_0 = f70;
        SrcA = a; SrcB = b; in_valid = 1'b1;
        #1;
        n = 0; sbad = 0;
        while (!out_valid && n < 60) begin
            if (!stall) sbad++;
            @(negedge clk);
            SrcA = $urandom; SrcB = $urandom;
            #1;
            n++;
        end
        chk({tag, "_lat"}, n, elat);
        chk({tag, "_res"}, ALUResult, er);
        chk({tag, "_zero"}, Zero, (er == 0));
        chk({tag, "_stall"}, {stall, 31'(sbad)}, 32'h0);
        in_valid = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b1; flush = 1'b0; in_valid = 1'b1;
        ALUOp = 2'b00; funct3 = 3'd0; op5 = 1'b0; funct7_5 = 1'b0; funct7_0 = 1'b0;
        SrcA = 32'd3; SrcB = 32'd4;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_res", ALUResult, 32'h0);
        chk("rst_zero", Zero, 1'b1);
        chk("rst_stall", stall, 1'b0);
        chk("rst_ov", out_valid, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;

        // Directed vectors from the block's worked examples.
        run_op("sub", 2'b10, 3'd0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7);
        run_op("mul", 2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        run_op("mulhu", 2'b10, 3'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd2);
        run_op("div", 2'b10, 3'd4, 1'b1, 1'b0, 1'b1, -32'sd7, 32'd2);
        run_op("rem", 2'b10, 3'd6, 1'b1, 1'b0, 1'b1, -32'sd7, 32'd2);
        run_op("divu0", 2'b10, 3'd5, 1'b1, 1'b0, 1'b1, 32'd123, 32'd0);
        run_op("divovf", 2'b10, 3'd4, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("removf", 2'b10, 3'd6, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("remu0", 2'b10, 3'd7, 1'b1, 1'b0, 1'b1, 32'd99, 32'd0);
        run_op("rsvd", 2'b11, 3'd5, 1'b1, 1'b0, 1'b1, 32'd10, 32'd20);

        // Flush of an in-flight DIVU at cycle 10.
        @(negedge clk);
        ALUOp = 2'b10; funct3 = 3'd5; op5 = 1'b1; funct7_5 = 1'b0; funct7_0 = 1'b1;
        SrcA = 32'd1000; SrcB = 32'd7; in_valid = 1'b1;
        for (n = 0; n < 10; n++) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("fl_ov10", out_valid, 1'b0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        chk("fl_stall11", stall, 1'b0);
        chk("fl_ov11", out_valid, 1'b0);
        ALUOp = 2'b00; SrcA = 32'd1; SrcB = 32'd1; in_valid = 1'b1;
        #1;
        chk("fl_add_res", ALUResult, 32'd2);
        chk("fl_add_ov", out_valid, 1'b1);
        chk("fl_add_stall", stall, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        repeat (40) begin @(negedge clk); #1; if (out_valid) n++; end
        chk("fl_no_ov", n, 0);

        // Reset in the middle of a MUL.
        @(negedge clk);
        ALUOp = 2'b10; funct3 = 3'd0; op5 = 1'b1; funct7_5 = 1'b0; funct7_0 = 1'b1;
        SrcA = 32'd12345; SrcB = 32'd678; in_valid = 1'b1;
        for (n = 0; n < 5; n++) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mr_res", ALUResult, 32'h0);
        chk("mr_stall", stall, 1'b0);
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        #1;
        chk("mr_res_post", ALUResult, 32'h0);
        chk("mr_zero_post", Zero, 1'b1);
        chk("mr_stall_post", stall, 1'b0);
        chk("mr_ov_post", out_valid, 1'b0);
        n = 0;
        repeat (40) begin @(negedge clk); #1; if (out_valid) n++; end
        chk("mr_no_ov", n, 0);

        // Randomized mix, biased toward funct-decoded ops.
        repeat (250) begin
            logic [1:0] aop;
            aop = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b10;
            run_op("rnd", aop, 3'($urandom_range(0, 7)), 1'($urandom), 1'($urandom),
                   1'($urandom), rnd_opnd(), rnd_opnd());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_muldiv_unit.md
ALU_MULDIV_UNIT -- requirements
Module: alu_muldiv_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; legal values 8, 16, 32, 64.
REQ-002 Parameter MDU_EN, default 1; 0 removes multiply/divide hardware.
REQ-003 clk  input  1  sole clock, all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 ALUOp  input  2  main-decoder class: 00 add, 01 subtract, 10 funct-decoded, 11 reserved.
REQ-006 funct3  input  3  instruction funct3.
REQ-007 op5  input  1  opcode bit 5 (1 = R-type).
REQ-008 funct7_5, funct7_0  input  1 each  funct7 bits 5 and 0.
REQ-009 SrcA, SrcB  input  XLEN each  operands.
REQ-010 in_valid  input  1  operands/controls valid this cycle.
REQ-011 flush  input  1  abort any in-flight multi-cycle op.
REQ-012 ALUResult  output  XLEN  result.
REQ-013 Zero  output  1  ALUResult == 0.
REQ-014 stall  output  1  pipeline must hold operands and controls.
REQ-015 out_valid  output  1  ALUResult valid this cycle.

Function
REQ-016 ALUOp 00 -> ADD; 01 -> SUB; 11 -> ADD.
REQ-017 ALUOp 10, funct7_0=0 or op5=0: funct3 000 ADD (SUB if op5&funct7_5), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7_5), 110 OR, 111 AND.
REQ-018 ALUOp 10, op5=1, funct7_0=1, MDU_EN=1: funct3 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU; with MDU_EN=0 these produce result 0, out_valid=1, stall=0.
REQ-019 Shift amount uses low log2(XLEN) bits of SrcB.
REQ-020 Non-M ops: combinational; out_valid = in_valid, stall = 0, same cycle.
REQ-021 FSM states IDLE, CALC, DONE; M-op with in_valid in IDLE latches operands, op and signs, enters CALC (cycle 0).
REQ-022 CALC: shift-add multiply or restoring divide on magnitudes, one bit per cycle, down-counter XLEN-1..0; exit to DONE after XLEN cycles.
REQ-023 DONE (cycle XLEN+1): ALUResult = sign-corrected result, out_valid=1, stall=0, one cycle; next state IDLE.
REQ-024 stall = 1 in cycle 0 and all CALC cycles; out_valid = 0 then.
REQ-025 MUL returns low XLEN bits of 2*XLEN product; MULH/MULHSU/MULHU return high XLEN bits with signed/signed, signed/unsigned, unsigned/unsigned operands.
REQ-026 Divide by zero: skip CALC, DONE at cycle 1; DIV/DIVU quotient all-ones, REM/REMU remainder = SrcA.
REQ-027 Signed overflow (SrcA = most-negative, SrcB = -1): skip CALC, DONE at cycle 1; DIV -> most-negative, REM -> 0.
REQ-028 Remainder sign follows dividend; quotient truncates toward zero.
REQ-029 flush in any state -> IDLE next cycle, no out_valid; flush has priority over in_valid.
REQ-030 Operand changes while stall=1 are ignored (latched copies used).
REQ-031 In DONE, a new M-op is not accepted until IDLE; Zero tracks ALUResult in all states.

Reset
REQ-032 rst=1 on a clock edge: state IDLE, counter 0, operand/accumulator registers 0.
REQ-033 During and after reset: ALUResult 0, Zero 1, stall 0, out_valid 0; reset mid-CALC discards the operation.

Structure
REQ-034 Shared package holds op-code enumeration (4-bit internal ALU control), FSM state encoding, ALUOp class constants.
REQ-035 One sub-module alu_muldiv_core (iterative multiply/divide datapath + counter); decode and combinational ALU in top.

Verification
REQ-036 XLEN=32, ALUOp=10, funct3=000, op5=1, funct7_5=1, A=5, B=7 -> ALUResult=0xFFFFFFFE, out_valid same cycle, stall 0.
REQ-037 MUL A=0xFFFFFFFF, B=2 -> stall cycles 0..32, cycle 33 out_valid with 0xFFFFFFFE; MULHU same operands -> 0x00000001.
REQ-038 DIV A=-7, B=2 -> quotient 0xFFFFFFFD; REM -> 0xFFFFFFFF; both at cycle 33.
REQ-039 DIVU A=123, B=0 -> 0xFFFFFFFF at cycle 1; DIV A=0x80000000, B=0xFFFFFFFF -> 0x80000000 at cycle 1.
REQ-040 Start DIVU, assert flush at cycle 10 -> IDLE at cycle 11, no out_valid; new ADD 1+1 -> 2 immediately.
REQ-041 rst at cycle 5 of MUL -> outputs at reset values next cycle, no out_valid ever for that op.
